// File: rtl/os_psum_collector.sv
// Output-stationary drain collector: turns one psum per column valid pulse into a
// per-lane FIFO entry and releases complete rows (one word per lane) on a pop.
module os_psum_collector #(
  parameter int COL    = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [COL*DATA_W-1:0] in,
  input  logic [COL-1:0]        valid_in,
  input  logic                  rd,
  output logic [COL*DATA_W-1:0] out,
  output logic                  o_valid,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [COL-1:0]             valid_in_p1;
  logic [COL-1:0]             cap;
  logic [COL-1:0]             lane_ne;
  logic [COL-1:0]             lane_full;
  logic [COL-1:0]             wr_en;
  logic [COL-1:0]             drop;
  logic                       pop;
  logic signed [DATA_W-1:0]   mem [COL][DEPTH];
  logic [PTR_W-1:0]           wr_ptr [COL];
  logic [PTR_W-1:0]           rd_ptr [COL];
  logic [CNT_W-1:0]           cnt [COL];

  // Stage p1: registered copy of the level valid, so a held level yields one capture
  always_ff @(posedge clk) begin
    if (reset) valid_in_p1 <= '0;
    else       valid_in_p1 <= valid_in;
  end

  assign cap = valid_in & ~valid_in_p1;

  always_comb begin
    lane_ne   = '0;
    lane_full = '0;
    for (int i = 0; i < COL; i++) begin
      lane_ne[i]   = (cnt[i] != '0);
      lane_full[i] = (cnt[i] == CNT_W'(DEPTH));
    end
  end

  assign o_valid = &lane_ne;
  assign o_empty = ~|lane_ne;
  assign o_full  = |lane_full;
  assign pop     = rd & o_valid;

  // A full lane can still accept a word when the same cycle pops its head
  assign wr_en = cap & (~lane_full | {COL{pop}});
  assign drop  = cap & lane_full & ~{COL{pop}};

  // Stage boundary: FIFO storage (data only, never reset)
  always_ff @(posedge clk) begin
    for (int i = 0; i < COL; i++) begin
      if (wr_en[i]) mem[i][wr_ptr[i]] <= in[i*DATA_W +: DATA_W];
    end
  end

  // Stage boundary: pointer, occupancy and sticky overflow control
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < COL; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
      o_overflow <= 1'b0;
    end else begin
      for (int i = 0; i < COL; i++) begin
        if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop)      rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        case ({wr_en[i], pop})
          2'b10:   cnt[i] <= cnt[i] + CNT_W'(1);
          2'b01:   cnt[i] <= cnt[i] - CNT_W'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
      if (|drop) o_overflow <= 1'b1;
    end
  end

  // Fall-through head of each lane, blanked until a full row is present
  for (genvar g = 0; g < COL; g++) begin : g_out
    assign out[g*DATA_W +: DATA_W] = o_valid ? mem[g][rd_ptr[g]] : '0;
  end

endmodule

// File: tb/tb_os_psum_collector.sv
// Randomised and directed bench for os_psum_collector against a queue-based lane model.
module tb_os_psum_collector;
  localparam int COL   = 8;
  localparam int W     = 16;
  localparam int DEPTH = 8;
  localparam int VW    = 4 + COL*W;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [COL*W-1:0]     in = '0;
  logic [COL-1:0]       valid_in = '0;
  logic                 rd = 1'b0;
  logic [COL*W-1:0]     out;
  logic                 o_valid, o_full, o_empty, o_overflow;

  int pass_cnt = 0;
  int total    = 0;

  os_psum_collector #(.COL(COL), .DATA_W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in(in), .valid_in(valid_in), .rd(rd),
    .out(out), .o_valid(o_valid), .o_full(o_full), .o_empty(o_empty),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  // Reference: one queue per lane, rising-edge capture, pop only when every lane has data
  logic [W-1:0]   mq [COL][$];
  logic [COL-1:0] m_vprev = '0;
  bit             m_ovf = 0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < COL; i++) mq[i].delete();
      m_vprev = '0;
      m_ovf   = 0;
    end else begin
      bit all_ne;
      bit do_pop;
      all_ne = 1;
      for (int i = 0; i < COL; i++) if (mq[i].size() == 0) all_ne = 0;
      do_pop = rd && all_ne;
      for (int i = 0; i < COL; i++) begin
        if (do_pop) void'(mq[i].pop_front());
        if (valid_in[i] && !m_vprev[i]) begin
          if (mq[i].size() < DEPTH) mq[i].push_back(in[i*W +: W]);
          else m_ovf = 1;
        end
      end
      m_vprev = valid_in;
    end
  end

  function automatic logic [VW-1:0] model_vec();
    logic v = 1'b1;
    logic e = 1'b1;
    logic f = 1'b0;
    logic [COL*W-1:0] d = '0;
    for (int i = 0; i < COL; i++) begin
      if (mq[i].size() == 0) v = 1'b0; else e = 1'b0;
      if (mq[i].size() == DEPTH) f = 1'b1;
    end
    if (v) for (int i = 0; i < COL; i++) d[i*W +: W] = mq[i][0];
    return {v, f, e, m_ovf, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_in();
    in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic do_reset();
    reset = 1'b1; valid_in = '0; rd = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic push_rows(input int n);
    for (int r = 0; r < n; r++) begin
      rand_in(); valid_in = '1; tick();
      valid_in = '0; tick();
    end
  endtask

  task automatic test_reset();
    logic [VW-1:0] want;
    do_reset();
    want = {1'b0, 1'b0, 1'b1, 1'b0, {(COL*W){1'b0}}};
    total++;
    if ({o_valid, o_full, o_empty, o_overflow, out} !== want) begin
      $display("FAIL reset_state: got %h want %h", {o_valid, o_full, o_empty, o_overflow, out}, want);
    end else pass_cnt++;
    rd = 1'b1; tick(); rd = 1'b0;
    total++;
    if ({o_valid, o_full, o_empty, o_overflow, out} !== want) begin
      $display("FAIL reset_rd_idle: got %h want %h", {o_valid, o_full, o_empty, o_overflow, out}, want);
    end else pass_cnt++;
  endtask

  task automatic test_row_pulse();
    logic [COL*W-1:0] row;
    for (int i = 0; i < COL; i++) row[i*W +: W] = 16'h0100 + W'(i);
    in = row; valid_in = '1; tick();
    valid_in = '0;
    total++;
    if (o_valid !== 1'b1 || out !== row) begin
      $display("FAIL row_pulse_out: got v=%b %h want v=1 %h", o_valid, out, row);
    end else pass_cnt++;
    rd = 1'b1; tick(); rd = 1'b0;
    total++;
    if (o_empty !== 1'b1 || o_valid !== 1'b0 || out !== '0) begin
      $display("FAIL row_pulse_pop: got e=%b v=%b out=%h want e=1 v=0 out=0", o_empty, o_valid, out);
    end else pass_cnt++;
  endtask

  task automatic test_held_valid();
    int bad = 0;
    rand_in(); valid_in = '1; tick();
    valid_in = 8'h01;
    for (int c = 1; c < 20; c++) begin
      rand_in(); tick();
      if ({o_valid, o_full, o_empty, o_overflow, out} !== model_vec()) bad++;
    end
    valid_in = '0;
    total++;
    if (bad != 0 || o_valid !== 1'b1) begin
      $display("FAIL held_valid_one_row: got %0d bad cycles v=%b want 0 bad v=1", bad, o_valid);
    end else pass_cnt++;
    rd = 1'b1; tick();
    total++;
    if (o_empty !== 1'b1) begin
      $display("FAIL held_valid_pop: got empty=%b want 1", o_empty);
    end else pass_cnt++;
    tick(); rd = 1'b0;
    total++;
    if ({o_valid, o_full, o_empty, o_overflow, out} !== {1'b0, 1'b0, 1'b1, 1'b0, {(COL*W){1'b0}}}) begin
      $display("FAIL held_valid_idle_rd: got %h want empty idle", {o_valid, o_full, o_empty, o_overflow, out});
    end else pass_cnt++;
  endtask

  task automatic test_skew();
    for (int c = 0; c < COL; c++) begin
      rand_in(); valid_in = COL'(1) << c; tick();
      total++;
      if (o_valid !== (c == COL-1) || {o_valid, o_full, o_empty, o_overflow, out} !== model_vec()) begin
        $display("FAIL skew_lane%0d: got v=%b %h want v=%b %h", c, o_valid, out, (c == COL-1), model_vec());
      end else pass_cnt++;
    end
    valid_in = '0;
    rd = 1'b1; tick(); rd = 1'b0;
    total++;
    if (o_empty !== 1'b1) begin
      $display("FAIL skew_pop: got empty=%b want 1", o_empty);
    end else pass_cnt++;
  endtask

  task automatic test_overflow();
    push_rows(DEPTH);
    total++;
    if (o_full !== 1'b1 || o_overflow !== 1'b0) begin
      $display("FAIL ovf_fill: got full=%b ovf=%b want full=1 ovf=0", o_full, o_overflow);
    end else pass_cnt++;
    rand_in(); valid_in = 8'h08; tick(); valid_in = '0; tick(); tick();
    total++;
    if (o_overflow !== 1'b1) begin
      $display("FAIL ovf_set: got %b want 1", o_overflow);
    end else pass_cnt++;
    for (int r = 0; r < DEPTH; r++) begin
      total++;
      if ({o_valid, o_full, o_empty, o_overflow, out} !== model_vec()) begin
        $display("FAIL ovf_pop_row%0d: got %h want %h", r, {o_valid, o_full, o_empty, o_overflow, out}, model_vec());
      end else pass_cnt++;
      rd = 1'b1; tick(); rd = 1'b0;
    end
    total++;
    if (o_empty !== 1'b1 || o_overflow !== 1'b1) begin
      $display("FAIL ovf_drained: got empty=%b ovf=%b want empty=1 ovf=1", o_empty, o_overflow);
    end else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [COL*W-1:0] new_row;
    do_reset();
    push_rows(DEPTH);
    rand_in(); new_row = in; valid_in = '1; rd = 1'b1; tick();
    valid_in = '0; rd = 1'b0;
    total++;
    if (o_full !== 1'b1 || o_overflow !== 1'b0) begin
      $display("FAIL wrap_same_cycle: got full=%b ovf=%b want full=1 ovf=0", o_full, o_overflow);
    end else pass_cnt++;
    for (int r = 0; r < DEPTH-1; r++) begin
      total++;
      if ({o_valid, o_full, o_empty, o_overflow, out} !== model_vec()) begin
        $display("FAIL wrap_pop%0d: got %h want %h", r, {o_valid, o_full, o_empty, o_overflow, out}, model_vec());
      end else pass_cnt++;
      rd = 1'b1; tick(); rd = 1'b0;
    end
    total++;
    if (o_valid !== 1'b1 || out !== new_row) begin
      $display("FAIL wrap_new_row: got v=%b %h want v=1 %h", o_valid, out, new_row);
    end else pass_cnt++;
    rd = 1'b1; tick(); rd = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [COL*W-1:0] held;
    do_reset();
    push_rows(5);
    rand_in(); held = in; valid_in = '1; reset = 1'b1; tick();
    total++;
    if (o_empty !== 1'b1 || o_overflow !== 1'b0 || o_valid !== 1'b0) begin
      $display("FAIL reset_mid_flags: got e=%b ovf=%b v=%b want e=1 ovf=0 v=0", o_empty, o_overflow, o_valid);
    end else pass_cnt++;
    reset = 1'b0; tick();
    total++;
    if (o_valid !== 1'b1 || out !== held) begin
      $display("FAIL reset_mid_recapture: got v=%b %h want v=1 %h", o_valid, out, held);
    end else pass_cnt++;
    rand_in(); tick(); tick();
    rd = 1'b1; tick(); rd = 1'b0; valid_in = '0;
    total++;
    if (o_empty !== 1'b1) begin
      $display("FAIL reset_mid_single: got empty=%b want 1", o_empty);
    end else pass_cnt++;
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rand_in();
      for (int i = 0; i < COL; i++) valid_in[i] = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 3) == 0);
      tick();
      if ({o_valid, o_full, o_empty, o_overflow, out} !== model_vec()) begin
        if (bad < 3) $display("FAIL random_cycle%0d: got %h want %h", c, {o_valid, o_full, o_empty, o_overflow, out}, model_vec());
        bad++;
      end
    end
    valid_in = '0; rd = 1'b0;
    total++;
    if (bad != 0) begin
      $display("FAIL random_total: got %0d bad cycles want 0", bad);
    end else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_row_pulse();
    test_held_valid();
    test_skew();
    test_overflow();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
